// File: rtl/lane_dly_seq_pkg.sv
// Shared types and encodings for the lane delay-line sequencer.
package lane_dly_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StStrobe,
    StGap,
    StPost,
    StFin
  } state_e;

  // REQ_OP encodings
  localparam logic OpMove = 1'b0;
  localparam logic OpLoad = 1'b1;

  // REQ_SEL / DELAY_LINE_SEL encodings
  localparam logic SelTx = 1'b0;
  localparam logic SelRx = 1'b1;

  // Width needed to hold a down-count starting at max_cycles - 1
  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/lane_dly_tapcnt.sv
// Saturating 8-bit up/down tap tracker with load to a fixed initial value.
module lane_dly_tapcnt #(
  parameter logic [7:0] INIT_TAP = 8'd1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       move_i,
  input  logic       dir_i,
  output logic [7:0] tap_o
);

  logic [7:0] tap_q, tap_d;

  // Next tap: load wins over move; moves saturate at 0 and 255
  always_comb begin
    tap_d = tap_q;
    if (load_i) begin
      tap_d = INIT_TAP;
    end else if (move_i) begin
      if (dir_i && (tap_q != 8'hFF)) begin
        tap_d = tap_q + 8'd1;
      end else if (!dir_i && (tap_q != 8'h00)) begin
        tap_d = tap_q - 8'd1;
      end
    end
  end

  // Tap register; position is not retained across reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap_q <= INIT_TAP;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign tap_o = tap_q;

endmodule

// File: rtl/lane_dly_seq.sv
// Delay-line move/load sequencer: wraps each request in an HS_IO_CLK_PAUSE
// window, issues spaced strobes and tracks the resulting tap per line.
module lane_dly_seq
  import lane_dly_seq_pkg::*;
#(
  parameter int unsigned PAUSE_SETUP = 4,
  parameter int unsigned MOVE_GAP    = 2,
  parameter int unsigned PAUSE_HOLD  = 4,
  parameter logic [7:0]  INIT_TAP    = 8'd1
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_OP,
  input  logic       REQ_SEL,
  input  logic       REQ_DIR,
  input  logic [7:0] REQ_STEPS,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] TX_TAP,
  output logic [7:0] RX_TAP,
  output logic       DELAY_LINE_SEL,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_MOVE,
  output logic       HS_IO_CLK_PAUSE,
  input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
  input  logic       RX_DELAY_LINE_OUT_OF_RANGE
);

  // Each phase counter is loaded with (length - 1); all lengths must be >= 1
  localparam int unsigned MaxSg  = (PAUSE_SETUP > MOVE_GAP) ? PAUSE_SETUP : MOVE_GAP;
  localparam int unsigned MaxCnt = (MaxSg > PAUSE_HOLD) ? MaxSg : PAUSE_HOLD;
  localparam int unsigned CntW   = cnt_width(MaxCnt);

  localparam logic [CntW-1:0] SetupLd = CntW'(PAUSE_SETUP - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(MOVE_GAP - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(PAUSE_HOLD - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      steps_q, steps_d;
  logic            op_q, op_d;
  logic            sel_q, sel_d;
  logic            dir_q, dir_d;
  logic            oor_q, oor_d;

  logic pause_q, pause_d;
  logic lsel_q, lsel_d;
  logic ldir_q, ldir_d;
  logic move_q, move_d;
  logic load_q, load_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic oor_sel;
  assign oor_sel = (sel_q == SelRx) ? RX_DELAY_LINE_OUT_OF_RANGE : TX_DELAY_LINE_OUT_OF_RANGE;

  // Next-state, phase counter and captured request fields
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    op_d    = op_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    oor_d   = oor_q;
    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          op_d  = REQ_OP;
          sel_d = REQ_SEL;
          dir_d = REQ_DIR;
          oor_d = 1'b0;
          if ((REQ_OP == OpMove) && (REQ_STEPS == 8'd0)) begin
            steps_d = 8'd0;
            state_d = StFin;
          end else begin
            steps_d = (REQ_OP == OpLoad) ? 8'd1 : REQ_STEPS;
            cnt_d   = SetupLd;
            state_d = StPre;
          end
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStrobe: begin
        steps_d = steps_q - 8'd1;
        cnt_d   = GapLd;
        state_d = StGap;
      end
      StGap: begin
        // A flag seen on any gap cycle ends the sequence once the gap completes
        if (oor_sel) begin
          oor_d = 1'b1;
        end
        if (cnt_q == '0) begin
          if ((steps_q == 8'd0) || oor_d) begin
            cnt_d   = HoldLd;
            state_d = StPost;
          end else begin
            state_d = StStrobe;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPost: begin
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Lane outputs are registered, so they are decoded from the next state
  always_comb begin
    pause_d = (state_d == StPre) || (state_d == StStrobe) ||
              (state_d == StGap) || (state_d == StPost);
    lsel_d  = pause_d & sel_d;
    ldir_d  = pause_d & dir_d;
    move_d  = (state_d == StStrobe) && (op_d == OpMove);
    load_d  = (state_d == StStrobe) && (op_d == OpLoad);
    done_d  = (state_d == StFin);
    err_d   = (state_d == StFin) && oor_d;
  end

  // State, sequencing registers and registered outputs
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      steps_q <= 8'd0;
      op_q    <= OpMove;
      sel_q   <= SelTx;
      dir_q   <= 1'b0;
      oor_q   <= 1'b0;
      pause_q <= 1'b0;
      lsel_q  <= 1'b0;
      ldir_q  <= 1'b0;
      move_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      oor_q   <= oor_d;
      pause_q <= pause_d;
      lsel_q  <= lsel_d;
      ldir_q  <= ldir_d;
      move_q  <= move_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  logic strobe_tx, strobe_rx;
  assign strobe_tx = (state_q == StStrobe) && (sel_q == SelTx);
  assign strobe_rx = (state_q == StStrobe) && (sel_q == SelRx);

  lane_dly_tapcnt #(
    .INIT_TAP (INIT_TAP)
  ) u_tx_tap (
    .clk_i  (FAB_CLK),
    .rst_i  (RESET),
    .load_i (strobe_tx && (op_q == OpLoad)),
    .move_i (strobe_tx && (op_q == OpMove)),
    .dir_i  (dir_q),
    .tap_o  (TX_TAP)
  );

  lane_dly_tapcnt #(
    .INIT_TAP (INIT_TAP)
  ) u_rx_tap (
    .clk_i  (FAB_CLK),
    .rst_i  (RESET),
    .load_i (strobe_rx && (op_q == OpLoad)),
    .move_i (strobe_rx && (op_q == OpMove)),
    .dir_i  (dir_q),
    .tap_o  (RX_TAP)
  );

  assign REQ_READY            = (state_q == StIdle);
  assign DONE                 = done_q;
  assign ERR                  = err_q;
  assign HS_IO_CLK_PAUSE      = pause_q;
  assign DELAY_LINE_SEL       = lsel_q;
  assign DELAY_LINE_DIRECTION = ldir_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_lane_dly_seq.sv
// Self-checking bench for lane_dly_seq: directed scenarios plus random
// requests, compared cycle by cycle against a timeline model.
module tb_lane_dly_seq;

  localparam int PS = 4;
  localparam int MG = 2;
  localparam int PH = 4;
  localparam int INIT = 1;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_op, req_sel, req_dir;
  logic [7:0] req_steps;
  logic       req_ready, done, err;
  logic [7:0] tx_tap, rx_tap;
  logic       dl_sel, dl_load, dl_dir, dl_move, pause;
  logic       tx_oor, rx_oor;

  int errors = 0;
  int checks = 0;
  int m_tx = INIT;
  int m_rx = INIT;

  always #5 clk = ~clk;

  lane_dly_seq dut (
    .FAB_CLK                    (clk),
    .RESET                      (rst),
    .REQ_VALID                  (req_valid),
    .REQ_READY                  (req_ready),
    .REQ_OP                     (req_op),
    .REQ_SEL                    (req_sel),
    .REQ_DIR                    (req_dir),
    .REQ_STEPS                  (req_steps),
    .DONE                       (done),
    .ERR                        (err),
    .TX_TAP                     (tx_tap),
    .RX_TAP                     (rx_tap),
    .DELAY_LINE_SEL             (dl_sel),
    .DELAY_LINE_LOAD            (dl_load),
    .DELAY_LINE_DIRECTION       (dl_dir),
    .DELAY_LINE_MOVE            (dl_move),
    .HS_IO_CLK_PAUSE            (pause),
    .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor),
    .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor)
  );

  // Cycle (accept = 0) of the k-th strobe
  function automatic int strobe_c(input int k);
    return PS + 1 + (k - 1) * (MG + 1);
  endfunction

  // Packed view: {ready, pause, sel, dir, move, load, done, err}
  function automatic logic [7:0] obs();
    return {req_ready, pause, dl_sel, dl_dir, dl_move, dl_load, done, err};
  endfunction

  // One request; oor_from = first cycle the selected flag is high
  task automatic run_req(input bit op, input bit sel, input bit dir, input int steps,
                         input int oor_from, input string tag);
    int n, m, done_c, k;
    bit e;
    logic [7:0] exp_v;
    bit p, mv, ld, st;
    n = op ? 1 : steps;
    m = n;
    e = 1'b0;
    if (n == 0) begin
      done_c = 1;
    end else begin
      for (int j = 1; j <= n; j++) begin
        if (strobe_c(j) + MG >= oor_from) begin
          m = j;
          e = 1'b1;
          break;
        end
      end
      done_c = strobe_c(m) + MG + PH + 1;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = 8'(steps);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 1'($urandom);
      req_steps = 8'($urandom);
      if (sel) begin
        rx_oor = (c >= oor_from);
        tx_oor = 1'($urandom);
      end else begin
        tx_oor = (c >= oor_from);
        rx_oor = 1'($urandom);
      end
      @(negedge clk);
      p  = (n > 0) && (c < done_c);
      st = (c >= PS + 1) && (((c - PS - 1) % (MG + 1)) == 0);
      k  = (c - PS - 1) / (MG + 1) + 1;
      mv = !op && st && (k <= m) && p;
      ld = op && (c == strobe_c(1));
      exp_v = {c == done_c + 1, p, p & sel, p & dir, mv, ld, c == done_c,
               (c == done_c) && e};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: {rdy,pause,sel,dir,move,load,done,err} got %b want %b",
                 tag, c, obs(), exp_v);
      end
    end
    tx_oor = 1'b0;
    rx_oor = 1'b0;
    for (int j = 0; j < m; j++) begin
      if (op) begin
        if (sel) m_rx = INIT;
        else     m_tx = INIT;
      end else if (sel) begin
        m_rx = dir ? ((m_rx < 255) ? m_rx + 1 : 255) : ((m_rx > 0) ? m_rx - 1 : 0);
      end else begin
        m_tx = dir ? ((m_tx < 255) ? m_tx + 1 : 255) : ((m_tx > 0) ? m_tx - 1 : 0);
      end
    end
    checks++;
    if ((int'(tx_tap) != m_tx) || (int'(rx_tap) != m_rx)) begin
      errors++;
      $display("FAIL %s taps: got tx=%0d rx=%0d want tx=%0d rx=%0d",
               tag, tx_tap, rx_tap, m_tx, m_rx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_sel = 1'b0; req_dir = 1'b0; req_steps = 8'd0;
    tx_oor = 1'b0; rx_oor = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_tx = INIT;
    m_rx = INIT;
    checks++;
    if ((obs() !== 8'b1000_0000) || (tx_tap !== 8'(INIT)) || (rx_tap !== 8'(INIT))) begin
      errors++;
      $display("FAIL reset_release: got out=%b tx=%0d rx=%0d want out=10000000 tx=1 rx=1",
               obs(), tx_tap, rx_tap);
    end
  endtask

  task automatic test_directed();
    run_req(1'b0, 1'b0, 1'b1, 3, NEVER, "move3_tx");
    checks++;
    if (tx_tap !== 8'd4) begin
      errors++;
      $display("FAIL move3_tx_tap: got %0d want 4", tx_tap);
    end
    run_req(1'b0, 1'b1, 1'b0, 0, NEVER, "steps0");
    run_req(1'b0, 1'b1, 1'b1, 5, NEVER, "move_rx");
    run_req(1'b1, 1'b1, 1'b0, 7, NEVER, "load_rx");
    checks++;
    if (rx_tap !== 8'd1) begin
      errors++;
      $display("FAIL load_rx_tap: got %0d want 1", rx_tap);
    end
    run_req(1'b1, 1'b0, 1'b1, 0, NEVER, "load_tx");
    run_req(1'b0, 1'b0, 1'b1, 10, 9, "oor_tx");
    checks++;
    if (tx_tap !== 8'd3) begin
      errors++;
      $display("FAIL oor_tx_tap: got %0d want 3", tx_tap);
    end
    run_req(1'b1, 1'b0, 1'b1, 0, NEVER, "load_tx2");
    run_req(1'b0, 1'b0, 1'b0, 3, NEVER, "sat_low");
    checks++;
    if (tx_tap !== 8'd0) begin
      errors++;
      $display("FAIL sat_low_tap: got %0d want 0", tx_tap);
    end
    run_req(1'b0, 1'b1, 1'b1, 255, NEVER, "sat_high");
    checks++;
    if (rx_tap !== 8'd255) begin
      errors++;
      $display("FAIL sat_high_tap: got %0d want 255", rx_tap);
    end
    run_req(1'b1, 1'b1, 1'b0, 0, 2, "load_oor");
  endtask

  task automatic test_random();
    bit op, sel, dir;
    int steps, oor_from;
    for (int i = 0; i < 40; i++) begin
      op       = ($urandom_range(0, 4) == 0);
      sel      = 1'($urandom);
      dir      = 1'($urandom);
      steps    = $urandom_range(0, 12);
      oor_from = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : NEVER;
      run_req(op, sel, dir, steps, oor_from, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_op = 1'b0; req_sel = 1'b1; req_dir = 1'b1; req_steps = 8'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ((obs() !== 8'b1000_0000) || (tx_tap !== 8'(INIT)) || (rx_tap !== 8'(INIT))) begin
      errors++;
      $display("FAIL reset_mid_async: got out=%b tx=%0d rx=%0d want out=10000000 tx=1 rx=1",
               obs(), tx_tap, rx_tap);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_tx = INIT;
    m_rx = INIT;
    checks++;
    if ((obs() !== 8'b1000_0000) || (tx_tap !== 8'(INIT)) || (rx_tap !== 8'(INIT))) begin
      errors++;
      $display("FAIL reset_mid_release: got out=%b tx=%0d rx=%0d want out=10000000 tx=1 rx=1",
               obs(), tx_tap, rx_tap);
    end
    run_req(1'b0, 1'b0, 1'b1, 2, NEVER, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_dly_seq.md
LANE_DLY_SEQ -- requirements
Module: lane_dly_seq

Interface
REQ-001 Parameters (name, default, meaning): PAUSE_SETUP, 4, HS_IO_CLK_PAUSE lead cycles before the first delay-line strobe; MOVE_GAP, 2, idle cycles after each MOVE pulse; PAUSE_HOLD, 4, pause trail cycles after the last strobe; INIT_TAP, 8'd1, tap value recorded on LOAD.
REQ-002 One clock, FAB_CLK; reset is RESET, asynchronous, active-high.
REQ-003 FAB_CLK  in  1  lane fabric clock; all logic is rising-edge.
REQ-004 RESET  in  1  asynchronous active-high reset.
REQ-005 REQ_VALID in 1 request present; REQ_READY out 1 sequencer idle.
REQ-006 REQ_OP in 1 (0 = MOVE, 1 = LOAD); REQ_SEL in 1 (0 = TX line, 1 = RX line); REQ_DIR in 1 (1 = increment); REQ_STEPS in 8 (number of MOVE strobes).
REQ-007 DONE out 1 single-cycle completion pulse; ERR out 1 single-cycle pulse, coincident with DONE, when the request ended on out-of-range.
REQ-008 TX_TAP, RX_TAP out 8 each: tracked tap position per line.
REQ-009 Lane side: DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE out 1 each, all registered; TX_DELAY_LINE_OUT_OF_RANGE, RX_DELAY_LINE_OUT_OF_RANGE in 1 each.

Function
REQ-010 States: IDLE, PRE, STROBE, GAP, POST, FIN.
REQ-011 REQ_READY = 1 only in IDLE; accept occurs on REQ_VALID & REQ_READY, and the request fields are captured at that edge.
REQ-012 If accepted with MOVE and REQ_STEPS = 0: go to FIN directly, with no pause and no strobe.
REQ-013 Otherwise go to PRE: HS_IO_CLK_PAUSE = 1, with SEL/DIRECTION driven from the captured fields, from the cycle after accept until POST ends.
REQ-014 PRE lasts PAUSE_SETUP cycles, then STROBE.
REQ-015 STROBE lasts exactly 1 cycle: DELAY_LINE_MOVE = 1 for MOVE, or DELAY_LINE_LOAD = 1 for LOAD; then GAP for MOVE_GAP cycles.
REQ-016 After GAP: return to STROBE if strobes remain, else go to POST.
REQ-017 LOAD issues exactly one strobe, independent of REQ_STEPS.
REQ-018 POST lasts PAUSE_HOLD cycles; FIN lasts 1 cycle with pause = 0 and DONE = 1; the next cycle is IDLE.
REQ-019 Each MOVE strobe increments or decrements the selected tap register, saturating at 0 and 255; LOAD sets the selected tap register to INIT_TAP.
REQ-020 The selected line's OUT_OF_RANGE input is sampled on every GAP cycle.
REQ-021 If OUT_OF_RANGE is 1 on a GAP cycle, the remaining strobes are abandoned, the state goes to POST, and ERR is latched and pulsed with DONE.
REQ-022 OUT_OF_RANGE is ignored outside GAP; the unselected line's flag is always ignored.
REQ-023 Strobe cycle timing, with accept = cycle 0 and defaults: k-th MOVE (k = 1..N) at cycle 3k+2; DONE at cycle 3N+9; pause high on cycles 1..3N+8.
REQ-024 All lane-side outputs are 0 in IDLE and FIN.

Reset
REQ-025 RESET asserted at any time, including mid-sequence: state = IDLE; all lane outputs, DONE and ERR = 0; REQ_READY = 1 after release; TX_TAP = RX_TAP = INIT_TAP.
REQ-026 The reset-driven deassertion of HS_IO_CLK_PAUSE mid-sequence is acceptable.
REQ-027 The tap registers do not retain their position across reset.

Structure
REQ-028 The state enumeration, the REQ_OP encodings and the sel encodings belong in a shared package.
REQ-029 One sub-module, lane_dly_tapcnt, holds the saturating 8-bit up/down counter with load; it is instantiated once per line.
REQ-030 Single counter for PRE/GAP/POST timing, sized to the maximum of the three parameters.

Verification
REQ-031 Reset release: REQ_READY = 1, TX_TAP = RX_TAP = 1, all lane outputs 0.
REQ-032 MOVE, TX, DIR = 1, STEPS = 3, defaults: MOVE pulses at cycles 5, 8, 11; DONE at cycle 18; pause high on cycles 1..17; TX_TAP = 4.
REQ-033 MOVE with STEPS = 0: DONE on cycle 1, no pause, taps unchanged.
REQ-034 LOAD, RX, after prior moves: a single LOAD pulse at cycle 5; DONE at cycle 12; RX_TAP = 1.
REQ-035 MOVE, TX, DIR = 1, STEPS = 10, with TX_OUT_OF_RANGE forced high from cycle 9: the 2nd strobe is the last; DONE = ERR = 1 at cycle 15; TX_TAP = 3.
REQ-036 DIR = 0 from TX_TAP = 1 with STEPS = 3: TX_TAP saturates at 0. RESET asserted at cycle 6 of a sequence: all outputs 0 and READY = 1 on the next cycle after release.
